// File: rtl/seq_ctrl.sv
`timescale 1ns/1ps
// seq_ctrl: control sequencer for the basic accumulator processor.
// It runs a fetch/decode/execute loop over the shared sysbus. Memory accesses
// hold CS until mem_rdy. The outputs are combinational from the state, op,
// z_flag and mem_rdy. While reset is high, every output is forced to 0.
// Optional feature: define SEQ_MEM_TIMEOUT_EN to bound memory waits to TIMEOUT
// cycles. An expired wait halts the sequencer with a sticky bus_err.
module seq_ctrl #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_rdy,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_xor,
  output logic            ALU_inc,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            load_MAR,
  output logic            CS,
  output logic            R_NW,
  output logic            halted,
  output logic            bus_err
);

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_INC   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_B = 3'd1,
    DECODE  = 3'd2,
    MEM     = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Every strobe except bus_err, which is registered separately.
  typedef struct packed {
    logic acc_bus;
    logic load_acc;
    logic alu_acc;
    logic alu_add;
    logic alu_sub;
    logic alu_xor;
    logic alu_inc;
    logic pc_bus;
    logic load_pc;
    logic inc_pc;
    logic load_ir;
    logic addr_bus;
    logic load_mar;
    logic cs;
    logic r_nw;
    logic halted;
  } ctrl_t;

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   wait_expired;

  // State register; asynchronous reset returns the sequencer to the start of fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH_A;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next = state_reg;
    ctrl       = '0;
    case (state_reg)
      FETCH_A: begin
        ctrl.pc_bus   = 1'b1;
        ctrl.load_mar = 1'b1;
        state_next    = FETCH_B;
      end
      FETCH_B: begin
        ctrl.cs   = 1'b1;
        ctrl.r_nw = 1'b1;
        if (mem_rdy) begin
          ctrl.load_ir = 1'b1;
          ctrl.inc_pc  = 1'b1;
          state_next   = DECODE;
        end else if (wait_expired) begin
          state_next = HALT;
        end
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: begin
            ctrl.addr_bus = 1'b1;
            ctrl.load_mar = 1'b1;
            state_next    = MEM;
          end
          OP_INC: begin
            ctrl.load_acc = 1'b1;
            ctrl.alu_acc  = 1'b1;
            ctrl.alu_inc  = 1'b1;
            state_next    = FETCH_A;
          end
          OP_BNE: begin
            // The branch is taken only when the accumulator is non-zero.
            if (!z_flag) begin
              ctrl.addr_bus = 1'b1;
              ctrl.load_pc  = 1'b1;
            end
            state_next = FETCH_A;
          end
          OP_HALT: state_next = HALT;
          default: state_next = FETCH_A;
        endcase
      end
      MEM: begin
        if (op == OP_STORE) begin
          // The accumulator drives the bus for the whole write. R_NW stays 0.
          ctrl.acc_bus = 1'b1;
          ctrl.cs      = 1'b1;
        end else begin
          ctrl.cs   = 1'b1;
          ctrl.r_nw = 1'b1;
          if (mem_rdy) begin
            case (op)
              OP_LOAD: ctrl.load_acc = 1'b1;
              OP_ADD: begin
                ctrl.load_acc = 1'b1;
                ctrl.alu_acc  = 1'b1;
                ctrl.alu_add  = 1'b1;
              end
              OP_SUB: begin
                ctrl.load_acc = 1'b1;
                ctrl.alu_acc  = 1'b1;
                ctrl.alu_sub  = 1'b1;
              end
              OP_XOR: begin
                ctrl.load_acc = 1'b1;
                ctrl.alu_acc  = 1'b1;
                ctrl.alu_xor  = 1'b1;
              end
              default: ctrl.load_acc = 1'b0;
            endcase
          end
        end
        if (mem_rdy) begin
          state_next = FETCH_A;
        end else if (wait_expired) begin
          state_next = HALT;
        end
      end
      HALT: ctrl.halted = 1'b1;
      default: state_next = FETCH_A;
    endcase
  end

  // Reset blanks every strobe immediately, which also drops CS in the middle of a wait.
  assign ctrl_out = reset ? ctrl_t'('0) : ctrl;

  assign ACC_bus  = ctrl_out.acc_bus;
  assign load_ACC = ctrl_out.load_acc;
  assign ALU_ACC  = ctrl_out.alu_acc;
  assign ALU_add  = ctrl_out.alu_add;
  assign ALU_sub  = ctrl_out.alu_sub;
  assign ALU_xor  = ctrl_out.alu_xor;
  assign ALU_inc  = ctrl_out.alu_inc;
  assign PC_bus   = ctrl_out.pc_bus;
  assign load_PC  = ctrl_out.load_pc;
  assign INC_PC   = ctrl_out.inc_pc;
  assign load_IR  = ctrl_out.load_ir;
  assign Addr_bus = ctrl_out.addr_bus;
  assign load_MAR = ctrl_out.load_mar;
  assign CS       = ctrl_out.cs;
  assign R_NW     = ctrl_out.r_nw;
  assign halted   = ctrl_out.halted;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  logic             in_wait;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             bus_err_reg;

  assign in_wait = (state_reg == FETCH_B) || (state_reg == MEM);

  // The wait expires when the TIMEOUT-th consecutive not-ready cycle occurs.
  // If mem_rdy is high in that cycle, the normal transition is taken instead.
  assign wait_expired = in_wait && !mem_rdy && (wait_cnt_reg == LAST_WAIT);

  // Count consecutive not-ready cycles. The count is zero whenever a wait state is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (in_wait && !mem_rdy) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  // Sticky bus error flag; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_err_reg <= 1'b0;
    end else if (wait_expired) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign bus_err = bus_err_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign wait_expired   = 1'b0;
  assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
`timescale 1ns/1ps
// tb_seq_ctrl: scoreboard bench for seq_ctrl. Each row of stimulus pushes its
// expected strobe vector, and that vector is popped and compared at the falling edge.
module tb_seq_ctrl;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_BNE   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Bit positions follow the outs concatenation below.
  localparam logic [16:0] O_ACCB  = 17'h10000;
  localparam logic [16:0] O_LACC  = 17'h08000;
  localparam logic [16:0] O_AACC  = 17'h04000;
  localparam logic [16:0] O_ADD   = 17'h02000;
  localparam logic [16:0] O_SUB   = 17'h01000;
  localparam logic [16:0] O_XOR   = 17'h00800;
  localparam logic [16:0] O_INC   = 17'h00400;
  localparam logic [16:0] O_PCB   = 17'h00200;
  localparam logic [16:0] O_LPC   = 17'h00100;
  localparam logic [16:0] O_INCPC = 17'h00080;
  localparam logic [16:0] O_LIR   = 17'h00040;
  localparam logic [16:0] O_ADRB  = 17'h00020;
  localparam logic [16:0] O_LMAR  = 17'h00010;
  localparam logic [16:0] O_CS    = 17'h00008;
  localparam logic [16:0] O_RNW   = 17'h00004;
  localparam logic [16:0] O_HLT   = 17'h00002;
  localparam logic [16:0] O_BERR  = 17'h00001;

  localparam logic [16:0] NONE    = 17'h00000;
  localparam logic [16:0] FA      = O_PCB | O_LMAR;
  localparam logic [16:0] FB_OK   = O_CS | O_RNW | O_LIR | O_INCPC;
  localparam logic [16:0] RD      = O_CS | O_RNW;
  localparam logic [16:0] DEC_MEM = O_ADRB | O_LMAR;
  localparam logic [16:0] EX_INC  = O_LACC | O_AACC | O_INC;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic       z;
    logic       rdy;
  } stim_t;

  logic clock;
  logic reset;
  logic [2:0] op;
  logic z_flag;
  logic mem_rdy;
  logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_inc;
  logic PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, CS, R_NW;
  logic halted, bus_err;
  logic [16:0] outs;

  stim_t       stim_q[$];
  logic [16:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic monitor_on = 1'b0;

  seq_ctrl #(.OP_W(3), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_rdy(mem_rdy),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .ALU_ACC(ALU_ACC),
    .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_xor(ALU_xor), .ALU_inc(ALU_inc),
    .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC), .load_IR(load_IR),
    .Addr_bus(Addr_bus), .load_MAR(load_MAR), .CS(CS), .R_NW(R_NW),
    .halted(halted), .bus_err(bus_err)
  );

  assign outs = {ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_inc,
                 PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, CS, R_NW,
                 halted, bus_err};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Sysbus single-driver and one-hot ALU select invariants, checked every cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (monitor_on) begin
        checks++;
        if (($countones({ACC_bus, PC_bus, Addr_bus, CS & R_NW}) > 1) ||
            ($countones({ALU_add, ALU_sub, ALU_xor, ALU_inc}) > 1)) begin
          errors++;
          $display("FAIL bus_excl drivers=%b alu_sel=%b want at most one set in each",
                   {ACC_bus, PC_bus, Addr_bus, CS & R_NW},
                   {ALU_add, ALU_sub, ALU_xor, ALU_inc});
        end
      end
    end
  end

  task automatic push(input logic rst, input logic [2:0] o, input logic z,
                      input logic rdy, input logic [16:0] e);
    stim_t s;
    s.rst = rst; s.op = o; s.z = z; s.rdy = rdy;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    for (int i = 0; i < 3; i++) push(1'b1, OP_INC, 1'b0, 1'b1, NONE);
    push(1'b0, OP_INC, 1'b0, 1'b1, FA);
    push(1'b0, OP_INC, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_INC, 1'b0, 1'b1, EX_INC);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("reset[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_add_wait();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_ADD, 1'b0, 1'b0, FA);
    push(1'b0, OP_ADD, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_ADD, 1'b0, 1'b0, DEC_MEM);
    push(1'b0, OP_ADD, 1'b0, 1'b0, RD);
    push(1'b0, OP_ADD, 1'b0, 1'b0, RD);
    push(1'b0, OP_ADD, 1'b0, 1'b1, RD | O_LACC | O_AACC | O_ADD);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL add_wait[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("add_wait[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_fetch_wait();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_LOAD, 1'b1, 1'b1, FA);
    push(1'b0, OP_LOAD, 1'b1, 1'b0, RD);
    push(1'b0, OP_LOAD, 1'b1, 1'b1, FB_OK);
    push(1'b0, OP_LOAD, 1'b1, 1'b1, DEC_MEM);
    push(1'b0, OP_LOAD, 1'b1, 1'b1, RD | O_LACC);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL load[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("load[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_sub_xor();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_SUB, 1'b0, 1'b1, FA);
    push(1'b0, OP_SUB, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_SUB, 1'b0, 1'b1, DEC_MEM);
    push(1'b0, OP_SUB, 1'b0, 1'b1, RD | O_LACC | O_AACC | O_SUB);
    push(1'b0, OP_XOR, 1'b0, 1'b1, FA);
    push(1'b0, OP_XOR, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_XOR, 1'b0, 1'b1, DEC_MEM);
    push(1'b0, OP_XOR, 1'b0, 1'b1, RD | O_LACC | O_AACC | O_XOR);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL sub_xor[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("sub_xor[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_store();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_STORE, 1'b0, 1'b1, FA);
    push(1'b0, OP_STORE, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_STORE, 1'b0, 1'b1, DEC_MEM);
    push(1'b0, OP_STORE, 1'b0, 1'b0, O_ACCB | O_CS);
    push(1'b0, OP_STORE, 1'b0, 1'b1, O_ACCB | O_CS);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL store[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("store[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_bne();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_BNE, 1'b1, 1'b1, FA);
    push(1'b0, OP_BNE, 1'b1, 1'b1, FB_OK);
    push(1'b0, OP_BNE, 1'b0, 1'b0, O_ADRB | O_LPC);
    push(1'b0, OP_BNE, 1'b0, 1'b1, FA);
    push(1'b0, OP_BNE, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_BNE, 1'b1, 1'b1, NONE);
    push(1'b0, OP_BNE, 1'b1, 1'b1, FA);
    push(1'b0, OP_INC, 1'b1, 1'b1, FB_OK);
    push(1'b0, OP_INC, 1'b1, 1'b1, EX_INC);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL bne[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("bne[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_halt();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_HALT, 1'b0, 1'b1, FA);
    push(1'b0, OP_HALT, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_HALT, 1'b0, 1'b1, NONE);
    for (int i = 0; i < 20; i++)
      push(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), O_HLT);
    push(1'b1, OP_INC, 1'b0, 1'b1, NONE);
    push(1'b0, OP_INC, 1'b0, 1'b1, FA);
    push(1'b0, OP_INC, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_INC, 1'b0, 1'b1, EX_INC);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL halt[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("halt[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask

`ifdef SEQ_MEM_TIMEOUT_EN
  task automatic test_timeout();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_INC, 1'b0, 1'b0, FA);
    for (int i = 0; i < 4; i++) push(1'b0, OP_INC, 1'b0, 1'b0, RD);
    for (int i = 0; i < 3; i++) push(1'b0, OP_INC, 1'b0, 1'($urandom_range(0, 1)), O_HLT | O_BERR);
    push(1'b1, OP_INC, 1'b0, 1'b0, NONE);
    push(1'b0, OP_INC, 1'b0, 1'b0, FA);
    for (int i = 0; i < 3; i++) push(1'b0, OP_INC, 1'b0, 1'b0, RD);
    push(1'b0, OP_INC, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_INC, 1'b0, 1'b1, EX_INC);
    push(1'b0, OP_INC, 1'b0, 1'b1, FA);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL timeout[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("timeout[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask
`else
  task automatic test_long_wait();
    stim_t s;
    logic [16:0] e;
    int n = 0;
    push(1'b0, OP_INC, 1'b0, 1'b0, FA);
    for (int i = 0; i < 8; i++) push(1'b0, OP_INC, 1'b0, 1'b0, RD);
    push(1'b0, OP_INC, 1'b0, 1'b1, FB_OK);
    push(1'b0, OP_INC, 1'b0, 1'b1, EX_INC);
    push(1'b0, OP_INC, 1'b0, 1'b1, FA);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; z_flag = s.z; mem_rdy = s.rdy;
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL long_wait[%0d] outs=%05h want=%05h", n, outs, e);
      end else $display("long_wait[%0d] outs=%05h", n, outs);
      n++;
      @(posedge clock); #1;
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    op      = OP_INC;
    z_flag  = 1'b0;
    mem_rdy = 1'b1;
    @(posedge clock); #1;
    monitor_on = 1'b1;
    test_reset();
    test_add_wait();
    test_load_fetch_wait();
    test_sub_xor();
    test_store();
    test_bne();
    test_halt();
`ifdef SEQ_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    monitor_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
